// File: rtl/stage2_pool_ctrl.sv
// -----------------------------------------------------------------------------
// stage2_pool_ctrl
//
// Sequencing controller for a 2x2 pooling stage. It walks one frame of
// PCH channels x PY rows x PX columns as pixels are accepted, and tells the
// pooling datapath what to do with each accepted pixel:
//   - write it into the line buffer (even rows),
//   - start a new 2x2 window (even row, even column),
//   - close a 2x2 window (odd row, odd column).
// A pooled result is flagged one cycle after the window-closing pixel,
// together with its output index within the channel.
//
// Optional feature (compile-time macro STAGE2_POOL_CTRL_STALLCNT_EN):
//   adds o_stall_cnt, a saturating count of RUN cycles in which upstream
//   offered a pixel but downstream back-pressure blocked it.
//
// Parameters
//   IBW  feature bit width (documents the datapath; no pixel data passes here)
//   PX   input columns
//   PY   input rows
//   PCH  channels per frame
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   i_start      frame start request (honoured in IDLE only)
//   o_busy       high from accepted start until the end of o_done
//   o_done       one-cycle end-of-frame pulse
//   i_in_valid   upstream pixel valid
//   o_in_ready   pixel can be accepted this cycle
//   i_ot_ready   downstream can take a pooled result
//   o_pool_en    datapath captures the current pixel
//   o_line_wr    pixel goes to the line buffer
//   o_win_first  first pixel of a 2x2 window
//   o_win_last   last pixel of a 2x2 window
//   o_row/o_col/o_ch  position of the current (next) input pixel
//   o_ot_valid   pooled result valid
//   o_ot_idx     pooled result index within the channel
//   o_stall_cnt  (optional) back-pressure stall counter
// -----------------------------------------------------------------------------
module stage2_pool_ctrl #(
   parameter int IBW = 19,
   parameter int PX  = 24,
   parameter int PY  = 24,
   parameter int PCH = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic        i_ot_ready,
   output logic        o_pool_en,
   output logic        o_line_wr,
   output logic        o_win_first,
   output logic        o_win_last,
   output logic [4:0]  o_row,
   output logic [4:0]  o_col,
   output logic [1:0]  o_ch,
   output logic        o_ot_valid,
   output logic [7:0]  o_ot_idx
`ifdef STAGE2_POOL_CTRL_STALLCNT_EN
   ,
   output logic [15:0] o_stall_cnt
`endif
);

   // IBW only documents the datapath width this controller sequences.
   if (IBW > 0) begin : g_ibw_doc
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Parity helper used by the window decode.
   function automatic logic is_odd(input logic [4:0] v);
      return v[0];
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;

   logic [4:0]  row_r;
   logic [4:0]  col_r;
   logic [1:0]  ch_r;
   logic        busy_r;
   logic        done_r;
   logic        ot_valid_r;
   logic [7:0]  ot_idx_r;

   logic        start_s;
   logic        in_ready_s;
   logic        accept_s;
   logic        col_last_s;
   logic        row_last_s;
   logic        ch_last_s;
   logic        frame_last_s;
   logic        line_wr_s;
   logic        win_first_s;
   logic        win_last_s;
   logic [7:0]  idx_s;

   // Handshake and position decode of the current pixel.
   always_comb begin
      start_s      = 1'b0;
      in_ready_s   = 1'b0;
      accept_s     = 1'b0;
      col_last_s   = (col_r == 5'(PX - 1));
      row_last_s   = (row_r == 5'(PY - 1));
      ch_last_s    = (ch_r == 2'(PCH - 1));
      frame_last_s = 1'b0;
      line_wr_s    = 1'b0;
      win_first_s  = 1'b0;
      win_last_s   = 1'b0;
      idx_s        = ({4'd0, row_r[4:1]} * 8'(PX / 2)) + {4'd0, col_r[4:1]};

      if (state_r == ST_IDLE) begin
         start_s = i_start;
      end else begin
         start_s = 1'b0;
      end

      if (state_r == ST_RUN) begin
         in_ready_s = i_ot_ready;
      end else begin
         in_ready_s = 1'b0;
      end

      accept_s     = in_ready_s && i_in_valid;
      frame_last_s = col_last_s && row_last_s && ch_last_s;

      // All datapath strobes are qualified by an actual acceptance.
      if (accept_s) begin
         line_wr_s   = !is_odd(row_r);
         win_first_s = !is_odd(row_r) && !is_odd(col_r);
         win_last_s  = is_odd(row_r) && is_odd(col_r);
      end else begin
         line_wr_s   = 1'b0;
         win_first_s = 1'b0;
         win_last_s  = 1'b0;
      end
   end

   // Next-state logic of the frame sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s && frame_last_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         // DRAIN covers the cycle in which the final pooled result is issued.
         ST_DRAIN: state_nxt_s = ST_DONE;
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // State register plus registered busy/done flags derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= (state_nxt_s == ST_DONE);
      end
   end

   // Row/column/channel walk; advances only on an accepted pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_r <= 5'd0;
         col_r <= 5'd0;
         ch_r  <= 2'd0;
      end else if (start_s) begin
         row_r <= 5'd0;
         col_r <= 5'd0;
         ch_r  <= 2'd0;
      end else if (accept_s) begin
         if (col_last_s) begin
            col_r <= 5'd0;
            if (row_last_s) begin
               row_r <= 5'd0;
               // Channel wraps after the last channel so the next frame starts clean.
               if (ch_last_s) begin
                  ch_r <= 2'd0;
               end else begin
                  ch_r <= ch_r + 2'd1;
               end
            end else begin
               row_r <= row_r + 5'd1;
            end
         end else begin
            col_r <= col_r + 5'd1;
         end
      end
   end

   // Pooled-result strobe and index, one cycle behind the window-closing pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         ot_valid_r <= 1'b0;
         ot_idx_r   <= 8'd0;
      end else begin
         ot_valid_r <= win_last_s;
         if (start_s) begin
            ot_idx_r <= 8'd0;
         end else if (win_last_s) begin
            ot_idx_r <= idx_s;
         end
      end
   end

`ifdef STAGE2_POOL_CTRL_STALLCNT_EN
   logic [15:0] stall_cnt_r;

   // Saturating count of RUN cycles blocked only by downstream back-pressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= 16'd0;
      end else if (start_s) begin
         stall_cnt_r <= 16'd0;
      end else if ((state_r == ST_RUN) && i_in_valid && !i_ot_ready &&
                   (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end
   end

   assign o_stall_cnt = stall_cnt_r;
`endif

   assign o_busy      = busy_r;
   assign o_done      = done_r;
   assign o_in_ready  = in_ready_s;
   assign o_pool_en   = accept_s;
   assign o_line_wr   = line_wr_s;
   assign o_win_first = win_first_s;
   assign o_win_last  = win_last_s;
   assign o_row       = row_r;
   assign o_col       = col_r;
   assign o_ch        = ch_r;
   assign o_ot_valid  = ot_valid_r;
   assign o_ot_idx    = ot_idx_r;

endmodule

// File: doc/stage2_pool_ctrl.md
STAGE2_POOL_CTRL -- requirements
Module: stage2_pool_ctrl

Interface
REQ-001 SHALL have parameters: IBW default 19 (input feature bit width, informational); PX default 24 (input columns); PY default 24 (input rows); PCH default 3 (channels per frame).
REQ-002 SHALL have ports as follows, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_start  in  1  frame start request.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse at frame end.
- i_in_valid  in  1  upstream pixel valid.
- o_in_ready  out  1  controller accepts pixel this cycle.
- i_ot_ready  in  1  downstream can take a pooled result.
- o_pool_en  out  1  pooling datapath captures the current pixel.
- o_line_wr  out  1  write pixel into line buffer (even row).
- o_win_first  out  1  first pixel of a 2x2 window (even row, even col).
- o_win_last  out  1  pixel completing a 2x2 window (odd row, odd col).
- o_row  out  5  current input row 0..PY-1.
- o_col  out  5  current input column 0..PX-1.
- o_ch  out  2  current channel 0..PCH-1.
- o_ot_valid  out  1  pooled result valid, one cycle after o_win_last.
- o_ot_idx  out  8  pooled output index 0..(PX/2)*(PY/2)-1 within the channel.

Function
REQ-003 SHALL implement FSM IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-004 IDLE->RUN on i_start=1; row, col, ch and output index cleared on that edge.
REQ-005 i_start outside IDLE SHALL be ignored.
REQ-006 o_in_ready SHALL equal (state==RUN) && i_ot_ready, combinationally.
REQ-007 A pixel is accepted iff i_in_valid && o_in_ready; o_pool_en SHALL equal that condition.
REQ-008 o_line_wr, o_win_first and o_win_last SHALL be qualified by o_pool_en and decode from o_row/o_col parity as defined in REQ-002.
REQ-009 On each accepted pixel col SHALL increment; at col==PX-1 col wraps to 0 and row increments; at row==PY-1 and col==PX-1, row wraps to 0 and ch increments.
REQ-010 Without an accepted pixel, row/col/ch SHALL hold.
REQ-011 o_ot_valid SHALL be registered: high exactly one cycle after each accepted o_win_last pixel.
REQ-012 o_ot_idx SHALL equal (row>>1)*(PX/2)+(col>>1) of the completing pixel, registered with o_ot_valid.
REQ-013 Acceptance of the last pixel (ch==PCH-1, row==PY-1, col==PX-1) SHALL move RUN->DRAIN.
REQ-014 DRAIN->DONE on the following edge, coincident with the final o_ot_valid.
REQ-015 DONE SHALL assert o_done for one cycle and return to IDLE.
REQ-016 o_busy SHALL be high in RUN, DRAIN and DONE.
REQ-017 i_ot_ready=0 SHALL stall acceptance only; an o_ot_valid already scheduled SHALL still be issued.
REQ-018 i_in_valid in IDLE, DRAIN or DONE SHALL not be accepted and SHALL not alter counters.

Reset
REQ-019 reset=1 at a rising edge SHALL force IDLE and clear row, col, ch, o_ot_valid, o_ot_idx and o_done to 0.
REQ-020 reset has priority over every other input, including mid-frame; o_in_ready, o_busy and o_pool_en read 0 during and after reset until the next i_start.

Configuration
REQ-021 Macro STAGE2_POOL_CTRL_STALLCNT_EN SHALL, when defined, add output o_stall_cnt (16 bits).
REQ-022 With the macro defined, o_stall_cnt SHALL count RUN cycles with i_in_valid=1 and i_ot_ready=0, saturate at 16'hFFFF, clear on reset and on accepted i_start.
REQ-023 With the macro undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 Start, then 1728 consecutive valid pixels with i_ot_ready=1 -> 432 o_ot_valid pulses; o_ot_idx 0..143 per channel; o_done exactly 2 cycles after last acceptance.
REQ-025 Pixel at row 1, col 1, ch 0 accepted -> o_win_last=1 that cycle; next cycle o_ot_valid=1 with o_ot_idx=0. Row 23, col 23 -> o_ot_idx=143.
REQ-026 i_ot_ready=0 for 10 cycles mid-row with i_in_valid=1 -> no acceptance, counters frozen, o_stall_cnt +10 when macro defined; resume continues at same row/col.
REQ-027 reset pulsed at pixel 500 -> next cycle IDLE, all outputs 0; new i_start restarts at row 0, col 0, ch 0.
REQ-028 i_start pulsed during RUN and valid pixels driven in IDLE -> no effect on counters or frame; output count still 432.
